// File: rtl/tdm_distributor_if.sv
// Handshake and per-channel output bundle for tdm_distributor.
// The slave modport is the distributor side; master is the word source and consumers.
interface tdm_distributor_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 8
);
  localparam int unsigned SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic                      iValid;
  logic                      oReady;
  logic [WIDTH-1:0]          iData;
  logic [SEL_W-1:0]          iSel;
  logic                      iMode;
  logic [CHANNELS*WIDTH-1:0] oData;
  logic [CHANNELS-1:0]       oStb_n;
  logic                      oFrame;
  logic                      oErr;
  logic [7:0]                oCount;

  modport slave (
    input  iValid, iData, iSel, iMode,
    output oReady, oData, oStb_n, oFrame, oErr, oCount
  );

  modport master (
    output iValid, iData, iSel, iMode,
    input  oReady, oData, oStb_n, oFrame, oErr, oCount
  );
endinterface

// File: rtl/tdm_distributor.sv
// Registered 1-to-CHANNELS word distributor, addressed or round-robin with a one-cycle frame gap.
// Define TDM_DIST_BLANK_EN to blank every unwritten slice to all ones each cycle.
module tdm_distributor #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 8
) (
  input logic              clk,
  input logic              rst_n,
  tdm_distributor_if.slave bus
);
  localparam int unsigned SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  typedef enum logic [0:0] {StRun, StGap} stateT;

  stateT                     stateQ, stateD;
  logic [SEL_W-1:0]          ptrQ, ptrD;
  logic [CHANNELS*WIDTH-1:0] dataQ, dataD;
  logic [CHANNELS-1:0]       stbQ, stbD;
  logic                      frameQ, frameD;
  logic                      errQ, errD;
  logic [7:0]                countQ, countD;

  logic             accept;
  logic             outOfRange;
  logic             wrEn;
  logic             lastSlot;
  logic             frameDone;
  logic [SEL_W-1:0] tgt;

  always_comb begin
    accept     = bus.iValid && (stateQ == StRun);
    // Only reachable when CHANNELS is not a power of two.
    outOfRange = !bus.iMode && (32'(bus.iSel) >= CHANNELS);
    wrEn       = accept && !outOfRange;
    tgt        = bus.iMode ? ptrQ : bus.iSel;
    lastSlot   = (ptrQ == SEL_W'(CHANNELS - 1));
    frameDone  = accept && bus.iMode && lastSlot;

    stateD = frameDone ? StGap : StRun;
    frameD = frameDone;
    errD   = accept && outOfRange;
    countD = frameDone ? countQ + 8'd1 : countQ;

    // Leaving round-robin mode always rewinds the pointer.
    if (!bus.iMode) begin
      ptrD = '0;
    end else if (accept) begin
      ptrD = lastSlot ? '0 : ptrQ + SEL_W'(1);
    end else begin
      ptrD = ptrQ;
    end

`ifdef TDM_DIST_BLANK_EN
    dataD = '1;
`else
    dataD = dataQ;
`endif
    stbD = '1;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (wrEn && (tgt == SEL_W'(k))) begin
        dataD[k*WIDTH +: WIDTH] = bus.iData;
        stbD[k]                 = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StRun;
      ptrQ   <= '0;
      dataQ  <= '1;
      stbQ   <= '1;
      frameQ <= 1'b0;
      errQ   <= 1'b0;
      countQ <= 8'd0;
    end else begin
      stateQ <= stateD;
      ptrQ   <= ptrD;
      dataQ  <= dataD;
      stbQ   <= stbD;
      frameQ <= frameD;
      errQ   <= errD;
      countQ <= countD;
    end
  end

  assign bus.oReady = (stateQ == StRun);
  assign bus.oData  = dataQ;
  assign bus.oStb_n = stbQ;
  assign bus.oFrame = frameQ;
  assign bus.oErr   = errQ;
  assign bus.oCount = countQ;
endmodule

// File: tb/tb_tdm_distributor.sv
// Directed bench for tdm_distributor: an 8-channel instance driven from a vector table and a
// 6-channel instance for out-of-range and mode-clear sequences.
module tb_tdm_distributor;
`ifdef TDM_DIST_BLANK_EN
  localparam bit Blank = 1'b1;
`else
  localparam bit Blank = 1'b0;
`endif

  logic clk;
  logic rst_n;

  tdm_distributor_if #(.WIDTH(8), .CHANNELS(8)) bus8 ();
  tdm_distributor_if #(.WIDTH(8), .CHANNELS(6)) bus6 ();

  tdm_distributor #(.WIDTH(8), .CHANNELS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  tdm_distributor #(.WIDTH(8), .CHANNELS(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       valid;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] expStb;
    logic       expReady;
    logic       expFrame;
    logic       expErr;
    logic [7:0] expCount;
  } vecT;

  vecT vecs[$];
  int  nChecks = 0;
  int  nPass   = 0;

  function automatic vecT mk(input logic v, input logic m, input logic [2:0] s,
                             input logic [7:0] d, input logic [7:0] st, input logic r,
                             input logic f, input logic e, input logic [7:0] c);
    vecT t;
    t.valid = v; t.mode = m; t.sel = s; t.data = d; t.expStb = st;
    t.expReady = r; t.expFrame = f; t.expErr = e; t.expCount = c;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic m, input logic [2:0] s, input logic [7:0] d);
    bus8.iValid = v; bus8.iMode = m; bus8.iSel = s; bus8.iData = d;
  endtask

  task automatic drive6(input logic v, input logic m, input logic [2:0] s, input logic [7:0] d);
    bus6.iValid = v; bus6.iMode = m; bus6.iSel = s; bus6.iData = d;
  endtask

  logic [63:0] expData8;

  initial begin
    drive8(1'b0, 1'b0, 3'd0, 8'h00);
    drive6(1'b0, 1'b0, 3'd0, 8'h00);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst data", bus8.oData, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst stb", bus8.oStb_n, 64'hFF);
    check("rst ready", bus8.oReady, 64'd1);
    check("rst count", bus8.oCount, 64'd0);
    check("rst frame", bus8.oFrame, 64'd0);
    check("rst err", bus8.oErr, 64'd0);
    check("rst data6", bus6.oData, 64'hFFFF_FFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Addressed write, hold, full round-robin frame, gap backpressure, blanking probe.
    vecs.push_back(mk(1, 0, 3'd5, 8'hA5, 8'hDF, 1, 0, 0, 8'd0));
    vecs.push_back(mk(0, 0, 3'd0, 8'h00, 8'hFF, 1, 0, 0, 8'd0));
    vecs.push_back(mk(0, 0, 3'd0, 8'h00, 8'hFF, 1, 0, 0, 8'd0));
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(1, 1, 3'd0, 8'(8'h10 + k), ~(8'd1 << k), (k != 7), (k == 7), 0,
                        (k == 7) ? 8'd1 : 8'd0));
    end
    vecs.push_back(mk(1, 1, 3'd0, 8'h18, 8'hFF, 1, 0, 0, 8'd1));
    vecs.push_back(mk(1, 1, 3'd0, 8'h18, 8'hFE, 1, 0, 0, 8'd1));
    vecs.push_back(mk(0, 1, 3'd0, 8'h00, 8'hFF, 1, 0, 0, 8'd1));
    vecs.push_back(mk(1, 0, 3'd2, 8'h3C, 8'hFB, 1, 0, 0, 8'd1));
    vecs.push_back(mk(0, 0, 3'd0, 8'h00, 8'hFF, 1, 0, 0, 8'd1));

    expData8 = '1;
    foreach (vecs[i]) begin
      drive8(vecs[i].valid, vecs[i].mode, vecs[i].sel, vecs[i].data);
      step();
      if (Blank) expData8 = '1;
      for (int k = 0; k < 8; k++) begin
        if (!vecs[i].expStb[k]) expData8[k*8 +: 8] = vecs[i].data;
      end
      check($sformatf("v%0d stb", i), bus8.oStb_n, vecs[i].expStb);
      check($sformatf("v%0d data", i), bus8.oData, expData8);
      check($sformatf("v%0d ready", i), bus8.oReady, vecs[i].expReady);
      check($sformatf("v%0d frame", i), bus8.oFrame, vecs[i].expFrame);
      check($sformatf("v%0d err", i), bus8.oErr, vecs[i].expErr);
      check($sformatf("v%0d count", i), bus8.oCount, vecs[i].expCount);
    end
    drive8(1'b0, 1'b0, 3'd0, 8'h00);

    // Six channels: out-of-range drops, in-range boundary, mode clear rewinds the pointer.
    drive6(1, 0, 3'd7, 8'h99);
    step();
    check("c6 err sel7", bus6.oErr, 64'd1);
    check("c6 stb sel7", bus6.oStb_n, 64'h3F);
    check("c6 data sel7", bus6.oData, 64'hFFFF_FFFF_FFFF);
    drive6(1, 0, 3'd6, 8'h98);
    step();
    check("c6 err sel6", bus6.oErr, 64'd1);
    check("c6 stb sel6", bus6.oStb_n, 64'h3F);
    drive6(1, 0, 3'd5, 8'h5A);
    step();
    check("c6 err sel5", bus6.oErr, 64'd0);
    check("c6 stb sel5", bus6.oStb_n, 64'h1F);
    check("c6 data sel5", bus6.oData, 64'h5AFF_FFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      drive6(1, 1, 3'd0, 8'(8'h20 + k));
      step();
      check($sformatf("c6 rr%0d stb", k), bus6.oStb_n, 64'(6'h3F & ~(6'd1 << k)));
    end
    drive6(0, 0, 3'd0, 8'h00);
    step();
    check("c6 clear stb", bus6.oStb_n, 64'h3F);
    drive6(1, 1, 3'd0, 8'h77);
    step();
    check("c6 reentry stb", bus6.oStb_n, 64'h3E);
    check("c6 reentry data", bus6.oData, Blank ? 64'hFFFF_FFFF_FF77 : 64'h5AFF_FF22_2177);
    check("c6 reentry frame", bus6.oFrame, 64'd0);
    drive6(0, 0, 3'd0, 8'h00);

    // Asynchronous reset mid-burst, then round-robin restarts at channel 0.
    drive8(1, 1, 3'd0, 8'h30);
    step();
    drive8(1, 1, 3'd0, 8'h31);
    step();
    check("burst stb", bus8.oStb_n, 64'hFD);
    #2 rst_n = 1'b0;
    #1;
    check("async data", bus8.oData, 64'hFFFF_FFFF_FFFF_FFFF);
    check("async stb", bus8.oStb_n, 64'hFF);
    check("async ready", bus8.oReady, 64'd1);
    check("async count", bus8.oCount, 64'd0);
    rst_n = 1'b1;
    drive8(1, 1, 3'd0, 8'h55);
    step();
    check("post-rst stb", bus8.oStb_n, 64'hFE);
    check("post-rst data", bus8.oData, 64'hFFFF_FFFF_FFFF_FF55);
    drive8(0, 0, 3'd0, 8'h00);
    step();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
